// File: rtl/scope_capture_ctrl_pkg.sv
// ============================================================================
// Module   : scope_capture_ctrl_pkg
// Purpose  : Shared sample widths, FSM state encoding and sign-extension helper
//            for the scope capture sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package scope_capture_ctrl_pkg;

    localparam int SMP_W  = 14;
    localparam int FIFO_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_CAPT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic logic [15:0] sext16(input logic [SMP_W-1:0] v);
        return {{(16-SMP_W){v[SMP_W-1]}}, v};
    endfunction

endpackage

`default_nettype wire

// File: rtl/scope_capture_ctrl_trig_detect.sv
// ============================================================================
// Module   : scope_trig_detect
// Purpose  : Level-crossing detector on channel A; combinational 1-cycle hit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module scope_trig_detect
    import scope_capture_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic             i_force_trig,
    input  logic             i_smp_valid,
    input  logic [SMP_W-1:0] i_smp_a,
    input  logic [SMP_W-1:0] i_level,
    input  logic             i_rising,
    output logic             o_hit
);

    logic signed [SMP_W-1:0] r_prev;
    logic                    r_prev_valid;
    logic signed [SMP_W-1:0] w_cur;
    logic signed [SMP_W-1:0] w_lvl;
    logic                    w_rise;
    logic                    w_fall;
    logic                    w_cross;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev       <= '0;
            r_prev_valid <= 1'b0;
        end else if (i_clr) begin
            r_prev_valid <= 1'b0;
        end else if (i_en && i_smp_valid) begin
            r_prev       <= i_smp_a;
            r_prev_valid <= 1'b1;
        end
    end

    // The first sample after arming only seeds r_prev, so no crossing can be seen.
    always_comb begin
        w_cur   = signed'(i_smp_a);
        w_lvl   = signed'(i_level);
        w_rise  = (r_prev < w_lvl) && (w_cur >= w_lvl);
        w_fall  = (r_prev > w_lvl) && (w_cur <= w_lvl);
        w_cross = r_prev_valid && (i_rising ? w_rise : w_fall);
        o_hit   = i_en && i_smp_valid && (i_force_trig || w_cross);
    end

endmodule

`default_nettype wire

// File: rtl/scope_capture_ctrl.sv
// ============================================================================
// Module   : scope_capture_ctrl
// Purpose  : Arms, waits for a channel-A trigger, then writes DEPTH decimated
//            sample pairs to the FIFO. Optional macro AUTO_TRIG_EN adds a
//            forced trigger after AUTO_TIMEOUT cycles in ARMED.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module scope_capture_ctrl
    import scope_capture_ctrl_pkg::*;
#(
    parameter int DEPTH        = 1024,
    parameter int CNT_W        = 11,
    parameter int AUTO_TIMEOUT = 1000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              arm,
    input  logic              abort,
    input  logic              smp_valid,
    input  logic [SMP_W-1:0]  smp_a,
    input  logic [SMP_W-1:0]  smp_b,
    input  logic [SMP_W-1:0]  trig_level,
    input  logic              trig_rising,
    input  logic [7:0]        decim,
    input  logic              full,
    output logic [FIFO_W-1:0] din,
    output logic              wr_en,
    output logic              busy,
    output logic              done,
    output logic              overrun,
    output logic [1:0]        state
);

    state_t             r_state;
    state_t             w_next;
    logic [SMP_W-1:0]   r_level;
    logic               r_rising;
    logic [7:0]         r_decim;
    logic [7:0]         r_dcnt;
    logic [CNT_W-1:0]   r_wcnt;
    logic [FIFO_W-1:0]  r_din;
    logic               r_wr_en;
    logic               r_overrun;

    logic               w_arm_ok;
    logic               w_hit;
    logic               w_force;
    logic               w_trig;
    logic               w_capt_smp;
    logic               w_due;
    logic               w_accept;
    logic               w_last;

    scope_trig_detect u_trig (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_clr        (w_arm_ok),
        .i_en         (r_state == ST_ARMED),
        .i_force_trig (w_force),
        .i_smp_valid  (smp_valid),
        .i_smp_a      (smp_a),
        .i_level      (r_level),
        .i_rising     (r_rising),
        .o_hit        (w_hit)
    );

`ifdef AUTO_TRIG_EN
    localparam int TMO_W = $clog2(AUTO_TIMEOUT + 1);
    logic [TMO_W-1:0] r_tmo_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo_cnt <= '0;
        end else if (r_state != ST_ARMED) begin
            r_tmo_cnt <= '0;
        end else if (r_tmo_cnt != TMO_W'(AUTO_TIMEOUT)) begin
            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
        end
    end

    assign w_force = (r_state == ST_ARMED) && (r_tmo_cnt == TMO_W'(AUTO_TIMEOUT));
`else
    logic w_unused_tmo;
    assign w_unused_tmo = (AUTO_TIMEOUT > 0);
    assign w_force      = 1'b0;
`endif

    // Abort outranks every other event, including a simultaneous arm or trigger.
    always_comb begin
        w_arm_ok   = (r_state == ST_IDLE) && arm && !abort;
        w_trig     = (r_state == ST_ARMED) && w_hit && !abort;
        w_capt_smp = (r_state == ST_CAPT) && smp_valid && !abort;
        w_due      = w_trig || (w_capt_smp && (r_dcnt == 8'd0));
        w_accept   = w_due && !full;
        w_last     = w_accept && (r_wcnt == CNT_W'(DEPTH - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_arm_ok) w_next = ST_ARMED;
            ST_ARMED: begin
                if (abort)       w_next = ST_IDLE;
                else if (w_trig) w_next = ST_CAPT;
            end
            ST_CAPT: begin
                if (abort)       w_next = ST_IDLE;
                else if (w_last) w_next = ST_DONE;
            end
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level   <= '0;
            r_rising  <= 1'b0;
            r_decim   <= '0;
            r_dcnt    <= '0;
            r_wcnt    <= '0;
            r_din     <= '0;
            r_wr_en   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_wr_en <= w_accept;
            if (w_arm_ok) begin
                r_level   <= trig_level;
                r_rising  <= trig_rising;
                r_decim   <= decim;
                r_wcnt    <= '0;
                r_overrun <= 1'b0;
            end
            if (w_trig) begin
                r_dcnt <= r_decim;
            end else if (w_capt_smp) begin
                r_dcnt <= (r_dcnt == 8'd0) ? r_decim : r_dcnt - 8'd1;
            end
            if (w_accept) begin
                r_din  <= {sext16(smp_a), sext16(smp_b)};
                r_wcnt <= r_wcnt + CNT_W'(1);
            end
            if (w_due && full) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign din     = r_din;
    assign wr_en   = r_wr_en;
    assign overrun = r_overrun;
    assign busy    = (r_state == ST_ARMED) || (r_state == ST_CAPT);
    assign done    = (r_state == ST_DONE);
    assign state   = r_state;

endmodule

`default_nettype wire

// File: tb/tb_scope_capture_ctrl.sv
// ============================================================================
// Module   : tb_scope_capture_ctrl
// Purpose  : Directed self-checking bench for scope_capture_ctrl (DEPTH=16).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_scope_capture_ctrl;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        arm = 1'b0;
    logic        abort = 1'b0;
    logic        smp_valid = 1'b0;
    logic [13:0] smp_a = '0;
    logic [13:0] smp_b = '0;
    logic [13:0] trig_level = '0;
    logic        trig_rising = 1'b0;
    logic [7:0]  decim = '0;
    logic        full = 1'b0;
    logic [31:0] din;
    logic        wr_en;
    logic        busy;
    logic        done;
    logic        overrun;
    logic [1:0]  state;

    int checks = 0;
    int errors = 0;
    int wr_total = 0;
    int done_total = 0;

    scope_capture_ctrl #(
        .DEPTH        (DEPTH),
        .CNT_W        (5),
        .AUTO_TIMEOUT (20)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .arm         (arm),
        .abort       (abort),
        .smp_valid   (smp_valid),
        .smp_a       (smp_a),
        .smp_b       (smp_b),
        .trig_level  (trig_level),
        .trig_rising (trig_rising),
        .decim       (decim),
        .full        (full),
        .din         (din),
        .wr_en       (wr_en),
        .busy        (busy),
        .done        (done),
        .overrun     (overrun),
        .state       (state)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_en === 1'b1) wr_total <= wr_total + 1;
        if (done === 1'b1)  done_total <= done_total + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic strobe(input int a, input int b);
        smp_a     = 14'(a);
        smp_b     = 14'(b);
        smp_valid = 1'b1;
        @(posedge clk);
        #1;
        smp_valid = 1'b0;
    endtask

    task automatic do_arm(input int lvl, input logic rising, input int dec);
        trig_level  = 14'(lvl);
        trig_rising = rising;
        decim       = 8'(dec);
        arm         = 1'b1;
        @(posedge clk);
        #1;
        arm = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
    endtask

    initial begin
        int wr_base;
        int done_base;

        // Reset state
        tick(3);
        check("rst_din", din, 32'h0);
        check("rst_wr_en", wr_en, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_overrun", overrun, 0);
        check("rst_state", state, 0);
        rst_n = 1'b1;
        tick(2);

        // Rising trigger on a ramp; writes 0,10,...,150
        wr_base   = wr_total;
        done_base = done_total;
        do_arm(0, 1'b1, 0);
        check("rise_state_armed", state, 1);
        check("rise_busy", busy, 1);
        for (int v = -100; v <= 150; v += 10) begin
            strobe(v, -5);
            if (v == -10) check("rise_no_trig_early", state, 1);
            if (v == 0) begin
                check("rise_first_we", wr_en, 1);
                check("rise_first_din", din, 32'h0000_FFFB);
                check("rise_state_capt", state, 2);
            end
            if (v == 150) begin
                check("rise_last_we", wr_en, 1);
                check("rise_done", done, 1);
                check("rise_state_done", state, 3);
            end
            tick(1);
        end
        check("rise_state_idle", state, 0);
        check("rise_done_low", done, 0);
        check("rise_wr_count", wr_total - wr_base, DEPTH);
        check("rise_done_count", done_total - done_base, 1);

        // Falling trigger, then abort after 7 writes
        wr_base   = wr_total;
        done_base = done_total;
        do_arm(50, 1'b0, 0);
        strobe(100, 1); tick(1);
        strobe(60, 1);  tick(1);
        check("fall_no_trig_60", state, 1);
        strobe(50, 1);
        check("fall_trig_we", wr_en, 1);
        check("fall_din_hi", din[31:16], 16'h0032);
        check("fall_state_capt", state, 2);
        tick(1);
        strobe(40, 1); tick(1);
        for (int i = 0; i < 5; i++) begin
            strobe(-8000, 2);
            tick(1);
        end
        check("fall_neg_din", din, 32'hE0C0_0002);
        check("abort_wr_count", wr_total - wr_base, 7);
        do_abort();
        check("abort_state", state, 0);
        check("abort_busy", busy, 0);
        tick(2);
        check("abort_no_done", done_total - done_base, 0);

        // Decimation by 4 over 40 strobes, plus an ignored arm while busy
        wr_base = wr_total;
        do_arm(0, 1'b1, 3);
        strobe(-20, 0); tick(1);
        strobe(-10, 0); tick(1);
        for (int i = 0; i < 40; i++) begin
            strobe((i == 0) ? 0 : 5, i);
            check($sformatf("decim_we_%0d", i), wr_en, (i % 4 == 0) ? 1 : 0);
            tick(1);
        end
        check("decim_wr_count", wr_total - wr_base, 10);
        do_arm(0, 1'b1, 0);
        check("arm_while_busy", state, 2);
        do_abort();
        check("decim_abort_state", state, 0);

        // Full backpressure: 5 dropped due writes mid-capture
        wr_base   = wr_total;
        done_base = done_total;
        do_arm(0, 1'b1, 0);
        check("full_overrun_clear", overrun, 0);
        strobe(-10, 0); tick(1);
        for (int v = 0; v <= 30; v += 10) begin
            strobe(v, 0);
            tick(1);
        end
        full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            strobe(40 + 10 * i, 0);
            check($sformatf("full_no_we_%0d", i), wr_en, 0);
            tick(1);
        end
        full = 1'b0;
        check("full_overrun_set", overrun, 1);
        check("full_state_capt", state, 2);
        for (int i = 0; i < 12; i++) begin
            strobe(100 + i, 0);
            if (i == 11) check("full_state_done", state, 3);
            tick(1);
        end
        check("full_wr_count", wr_total - wr_base, DEPTH);
        check("full_done_count", done_total - done_base, 1);
        check("full_overrun_sticky", overrun, 1);

        // arm and abort together: abort wins, overrun untouched
        arm   = 1'b1;
        abort = 1'b1;
        tick(1);
        arm   = 1'b0;
        abort = 1'b0;
        check("arm_abort_state", state, 0);
        check("arm_abort_overrun", overrun, 1);
        tick(1);
        check("arm_abort_stays", state, 0);

        // Auto trigger on constant input
        do_arm(0, 1'b1, 0);
        check("arm_clears_overrun", overrun, 0);
        tick(19);
        strobe(7, 3);
        check("auto_before_tmo", state, 1);
        strobe(7, 3);
`ifdef AUTO_TRIG_EN
        check("auto_trig_state", state, 2);
        check("auto_trig_we", wr_en, 1);
`else
        check("auto_none_state", state, 1);
        check("auto_none_we", wr_en, 0);
`endif
        tick(1);
        do_abort();
        check("auto_abort_state", state, 0);

        // Asynchronous reset mid-capture
        done_base = done_total;
        do_arm(0, 1'b1, 0);
        strobe(-10, -5); tick(1);
        strobe(0, -5);
        check("rstmid_pre_we", wr_en, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstmid_din", din, 32'h0);
        check("rstmid_wr_en", wr_en, 0);
        check("rstmid_busy", busy, 0);
        check("rstmid_state", state, 0);
        tick(2);
        rst_n = 1'b1;
        tick(2);
        check("rstmid_no_done", done_total - done_base, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
